// File: rtl/hazard_tracker.sv
// Purpose: load-use stall and per-source forwarding selects for the ID instruction, shadowing EX..WB with a tag shift register.
// Latency: stall and forwarding selects are combinational from ID inputs and tags; tags advance one stage per clk1 edge.
// Backpressure: stall holds IF/ID and injects a bubble into EX; older tags always advance, and flush kills the ID tag.
module hazard_tracker #(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter int CNT_W      = 16,
  parameter int SW         = $clog2(STAGES + 1)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic              stall,
  output logic [SW-1:0]     fwd_sel1,
  output logic [SW-1:0]     fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  // One in-flight instruction tag; index k of the array is pipeline stage k (1 = EX).
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } entry_t;

  entry_t            entry_q [1:STAGES];
  entry_t            entry_d [1:STAGES];
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  logic [SW-1:0]     sel1_raw;
  logic [SW-1:0]     sel2_raw;
  logic              nrdy1;
  logic              nrdy2;

  // True when a tag would supply the value for source address rs.
  function automatic logic tag_hit(input entry_t e, input logic [REG_AW-1:0] rs,
                                   input logic used);
    logic zero_blocked;
    zero_blocked = ZERO_REG && (rs == '0);
    return e.v && e.we && (e.rd == rs) && used && !zero_blocked;
  endfunction

  // Youngest matching producer per source: scan oldest to youngest so the
  // lowest stage index overwrites; only that producer's readiness matters.
  always_comb begin
    sel1_raw = '0;
    sel2_raw = '0;
    nrdy1    = 1'b0;
    nrdy2    = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (tag_hit(entry_q[k], id_rs1, id_rs1_used)) begin
        sel1_raw = SW'(k);
        nrdy1    = entry_q[k].ld && (k < LOAD_STAGE);
      end
      if (tag_hit(entry_q[k], id_rs2, id_rs2_used)) begin
        sel2_raw = SW'(k);
        nrdy2    = entry_q[k].ld && (k < LOAD_STAGE);
      end
    end
  end

  // Outputs: an empty ID slot never forwards, and a flushed slot never stalls.
  always_comb begin
    fwd_sel1 = id_valid ? sel1_raw : '0;
    fwd_sel2 = id_valid ? sel2_raw : '0;
    stall    = id_valid && !flush && (nrdy1 || nrdy2);
  end

  // Next tag state: everything advances; EX receives the ID tag or a bubble.
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      entry_d[k] = '0;
    end
    for (int k = 2; k <= STAGES; k++) begin
      entry_d[k] = entry_q[k-1];
    end
    if (id_valid && !stall && !flush) begin
      entry_d[1] = '{v: 1'b1, rd: id_rd, we: id_we, ld: id_is_load};
    end
  end

  // Saturating stall-cycle counter; it never wraps back to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers; reset discards all in-flight tags and clears the counter.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= STAGES; k++) begin
        entry_q[k] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        entry_q[k] <= entry_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: default instance for forwarding/stall/flush,
// plus an 8-bit-counter instance to reach counter saturation in few cycles.
module tb_hazard_tracker;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [15:0] stall_cnt;

  logic        s_valid, s_rs1_used, s_rs2_used, s_we, s_is_load, s_flush;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic        s_stall;
  logic [1:0]  s_sel1, s_sel2;
  logic [7:0]  s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk1 = ~clk1;

  hazard_tracker dut (
    .clk1(clk1), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt)
  );

  hazard_tracker #(.CNT_W(8)) dut_s (
    .clk1(clk1), .rst(rst), .id_valid(s_valid), .id_rs1(s_rs1), .id_rs2(s_rs2),
    .id_rs1_used(s_rs1_used), .id_rs2_used(s_rs2_used), .id_rd(s_rd), .id_we(s_we),
    .id_is_load(s_is_load), .flush(s_flush), .stall(s_stall), .fwd_sel1(s_sel1),
    .fwd_sel2(s_sel2), .stall_cnt(s_cnt)
  );

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl);
    id_valid = v;   id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd;     id_we = we;   id_is_load = ld;  flush = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(0);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL por_stall: got %0b want 0", stall); end
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL por_sel1: got %0d want 0", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'd0) begin bad++; $display("FAIL por_sel2: got %0d want 0", fwd_sel2); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL por_cnt: got %0d want 0", stall_cnt); end
    tick(); tick();
    rst = 1'b1;
    // add x5, add x6, lw x7 fill all three stages
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();
    drive(1, 5, 1, 7, 1, 9, 1, 0, 0);
    total++; if (fwd_sel1 !== 2'd3) begin bad++; $display("FAIL pre_rst_sel1: got %0d want 3", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'd1) begin bad++; $display("FAIL pre_rst_sel2: got %0d want 1", fwd_sel2); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL pre_rst_stall: got %0b want 1", stall); end
    rst = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %0b want 0", stall); end
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL rst_sel1: got %0d want 0", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'd0) begin bad++; $display("FAIL rst_sel2: got %0d want 0", fwd_sel2); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst = 1'b1;
    drive(1, 5, 1, 7, 1, 9, 1, 0, 0);
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL post_rst_sel1: got %0d want 0", fwd_sel1); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL post_rst_stall: got %0b want 0", stall); end
    idle(3);
  endtask

  task automatic test_alu_chain();
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd3; exp_sel[3] = 2'd0;
    for (int g = 0; g < 4; g++) begin
      idle(3);
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
      for (int j = 0; j < g; j++) begin
        drive(1, 11, 1, 12, 1, 5'(10 + j), 1, 0, 0); tick();
      end
      drive(1, 5, 1, 0, 0, 6, 1, 0, 0);
      total++; if (fwd_sel1 !== exp_sel[g]) begin bad++; $display("FAIL alu_gap%0d_sel1: got %0d want %0d", g, fwd_sel1, exp_sel[g]); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_gap%0d_stall: got %0b want 0", g, stall); end
      total++; if (fwd_sel2 !== 2'd0) begin bad++; $display("FAIL alu_gap%0d_sel2: got %0d want 0", g, fwd_sel2); end
      tick();
    end
    idle(3);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(1, 0, 0, 5, 1, 6, 1, 0, 0);
    total++; if (fwd_sel2 !== 2'd1) begin bad++; $display("FAIL alu_rs2_sel2: got %0d want 1", fwd_sel2); end
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL alu_rs2_sel1: got %0d want 0", fwd_sel1); end
    tick();
    idle(3);
  endtask

  task automatic test_load_use();
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL lu_cnt0: got %0d want 0", stall_cnt); end
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();          // lw x7
    drive(1, 1, 1, 7, 1, 8, 1, 0, 0);                   // add x8, x1, x7
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %0b want 1", stall); end
    total++; if (fwd_sel2 !== 2'd1) begin bad++; $display("FAIL lu_sel2_stage1: got %0d want 1", fwd_sel2); end
    tick();
    // reads x8 (bubble must hide it) and x7 (load now in stage 2)
    drive(1, 8, 1, 7, 1, 9, 1, 0, 0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_after: got %0b want 0", stall); end
    total++; if (fwd_sel2 !== 2'd2) begin bad++; $display("FAIL lu_sel2_after: got %0d want 2", fwd_sel2); end
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL lu_bubble_sel1: got %0d want 0", fwd_sel1); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); end
    tick();
    idle(3);
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt_hold: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_zero_unused();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0); tick();          // lw x0
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0);
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL x0_sel1: got %0d want 0", fwd_sel1); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall: got %0b want 0", stall); end
    tick(); idle(3);
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0); tick();          // lw x9
    drive(1, 0, 0, 9, 0, 4, 1, 0, 0);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL unused_stall: got %0b want 0", stall); end
    total++; if (fwd_sel2 !== 2'd0) begin bad++; $display("FAIL unused_sel2: got %0d want 0", fwd_sel2); end
    tick(); idle(3);
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); tick();
    drive(0, 5, 1, 5, 1, 4, 1, 0, 0);
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL novalid_sel1: got %0d want 0", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'd0) begin bad++; $display("FAIL novalid_sel2: got %0d want 0", fwd_sel2); end
    tick(); idle(3);
  endtask

  task automatic test_youngest_flush();
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();          // lw x3
    drive(1, 1, 1, 0, 0, 3, 1, 0, 0); tick();          // addi x3, x1
    drive(1, 3, 1, 0, 0, 4, 1, 0, 0);
    total++; if (fwd_sel1 !== 2'd1) begin bad++; $display("FAIL yw_alu_sel1: got %0d want 1", fwd_sel1); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL yw_alu_stall: got %0b want 0", stall); end
    tick(); idle(3);
    drive(1, 1, 1, 0, 0, 3, 1, 0, 0); tick();          // addi x3
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0); tick();          // lw x3 (youngest)
    drive(1, 0, 0, 3, 1, 4, 1, 0, 0);
    total++; if (fwd_sel2 !== 2'd1) begin bad++; $display("FAIL yw_ld_sel2: got %0d want 1", fwd_sel2); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL yw_ld_stall: got %0b want 1", stall); end
    tick(); idle(3);
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL yw_cnt: got %0d want 2", stall_cnt); end
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0); tick();          // lw x7
    drive(1, 1, 1, 7, 1, 8, 1, 0, 1);                   // flushed consumer
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall: got %0b want 0", stall); end
    tick();
    drive(1, 8, 1, 7, 1, 9, 1, 0, 0);
    total++; if (fwd_sel1 !== 2'd0) begin bad++; $display("FAIL fl_bubble_sel1: got %0d want 0", fwd_sel1); end
    total++; if (fwd_sel2 !== 2'd2) begin bad++; $display("FAIL fl_sel2: got %0d want 2", fwd_sel2); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL fl_cnt: got %0d want 2", stall_cnt); end
    tick(); idle(3);
  endtask

  task automatic test_saturation();
    total++; if (s_cnt !== 8'd0) begin bad++; $display("FAIL sat_cnt0: got %0d want 0", s_cnt); end
    // lw x7 that reads x7: stalls every second cycle
    s_valid = 1; s_rs1 = 7; s_rs1_used = 1; s_rs2 = 0; s_rs2_used = 0;
    s_rd = 7; s_we = 1; s_is_load = 1; s_flush = 0;
    repeat (508) tick();
    total++; if (s_cnt !== 8'd254) begin bad++; $display("FAIL sat_cnt254: got %0d want 254", s_cnt); end
    total++; if (s_stall !== 1'b0) begin bad++; $display("FAIL sat_phase0: got %0b want 0", s_stall); end
    tick();
    total++; if (s_stall !== 1'b1) begin bad++; $display("FAIL sat_phase1: got %0b want 1", s_stall); end
    tick();
    total++; if (s_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt255: got %0d want 255", s_cnt); end
    repeat (21) tick();
    total++; if (s_stall !== 1'b1) begin bad++; $display("FAIL sat_still_stall: got %0b want 1", s_stall); end
    total++; if (s_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", s_cnt); end
    s_valid = 0;
  endtask

  initial begin
    s_valid = 0; s_rs1 = 0; s_rs1_used = 0; s_rs2 = 0; s_rs2_used = 0;
    s_rd = 0; s_we = 0; s_is_load = 0; s_flush = 0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero_unused();
    test_youngest_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC pipeline.
- Sits beside decode and shadows the post-decode stages (EX, MEM, WB by default) with a tag shift register.
- For the instruction in ID it produces a load-use stall and per-source forwarding selects.
- Generalises depth, register-address width and load latency, adds flush handling, and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_AW, 5, register address width (2^REG_AW architectural registers).
- STAGES, 3, number of post-decode stages tracked; stage 1 = EX, stage STAGES = last writeback stage. Must be ≥ 2.
- LOAD_STAGE, 2, first stage index at which load data is forwardable. Range 1..STAGES.
- ZERO_REG, 1, when 1 register 0 never creates a hazard or forward.
- CNT_W, 16, width of the stall counter.
- SW, $clog2(STAGES+1), width of the forwarding selects (derived; do not override).

Ports:
- clk1, in, 1, single clock; all state updates on the rising edge.
- rst, in, 1, asynchronous active-low reset.
- id_valid, in, 1, ID holds a real instruction.
- id_rs1, in, REG_AW, source 1 address.
- id_rs2, in, REG_AW, source 2 address.
- id_rs1_used, in, 1, instruction reads rs1.
- id_rs2_used, in, 1, instruction reads rs2.
- id_rd, in, REG_AW, destination address.
- id_we, in, 1, instruction writes rd.
- id_is_load, in, 1, instruction is a load.
- flush, in, 1, kill the ID instruction (taken branch/jump).
- stall, out, 1, hold IF/ID and insert a bubble into EX.
- fwd_sel1, out, SW, 0 = register file; k = producer currently in stage k.
- fwd_sel2, out, SW, same encoding for rs2.
- stall_cnt, out, CNT_W, saturating count of stall cycles.

Behaviour:
- State: entries e[1..STAGES], each {v, rd, we, ld}.
- Reset (rst=0, async): all e[k].v=0, stall_cnt=0. Hence stall=0 and fwd_sel1=fwd_sel2=0 while reset is held. Reset mid-operation discards all in-flight tags.
- Shift each clk1 edge:
  - e[k] <= e[k-1] for k=2..STAGES; the entry in e[STAGES] retires.
  - e[1] <= {id_valid, id_rd, id_we, id_is_load} only when id_valid=1, stall=0 and flush=0.
  - Otherwise e[1] <= bubble (v=0). Older entries always advance; a stall never freezes them.
- Match m(k,rs): e[k].v & e[k].we & (e[k].rd==rs) & rs_used & !(ZERO_REG & rs==0).
- Forward select:
  - fwd_selN = smallest k with m(k,rsN) true, so the youngest producer wins.
  - fwd_selN = 0 if no match or id_valid=0.
  - Combinational from current entries and ID inputs.
- Readiness: a matched entry is ready if e[k].ld=0 or k ≥ LOAD_STAGE.
- Stall:
  - stall = id_valid & !flush & (youngest match for rs1 not ready | youngest match for rs2 not ready).
  - Only the youngest match is evaluated; an older unready load behind a younger ALU writer causes no stall.
  - flush=1 forces stall=0.
  - With the defaults, a load-use pair costs exactly one bubble.
- Counter:
  - stall_cnt increments by 1 on each edge where stall=1.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - Only rst clears it.
- Outputs are combinational; the datapath uses fwd_selN as the producer's stage when the consumer was in ID.

Test Plan:
1. Reset → with rst=0 asserted mid-stream and 3 entries valid, all outputs read stall=0, fwd_sel1/2=0, stall_cnt=0 immediately (async). After release, a reader of x5 gets fwd_sel1=0.
2. ALU chain → issue add x5, then sub reading rs1=x5 on the next cycle: fwd_sel1=1, stall=0. With one unrelated instruction in between instead: fwd_sel1=2. With two in between: fwd_sel1=3. With three in between: fwd_sel1=0.
3. Load-use → lw x7, then add reading rs2=x7: stall=1 for exactly one cycle and e[1] becomes a bubble. Next cycle fwd_sel2=2, stall=0, stall_cnt=1.
4. x0 and unused sources → a writer with rd=0 followed by a reader with rs1=0 gives fwd_sel1=0, stall=0. A load to x9 followed by an instruction with rs2=x9 but id_rs2_used=0 gives stall=0.
5. Youngest wins and flush →
   - Sequence lw x3, addi x3, then a reader of x3: fwd_sel1=1, stall=0.
   - Load-use pair with flush=1: stall=0, and e[1].v=0 on the next cycle.
6. Saturation → force 65535 stall cycles, then continue stalling: stall_cnt holds at 0xFFFF.
